// File: rtl/uart_rx_cfg_if.sv
// Receiver-side bundle for uart_rx_cfg: serial line and flow control in,
// received word plus status out. The master modport is the line/consumer side.
interface uart_rx_cfg_if #(
  parameter int WIDTH = 8
);
  logic             signal;
  logic             can_receive_next_word;
  logic [WIDTH-1:0] data;
  logic             ready;
  logic             parity_error;
  logic             frame_error;
  logic             busy;

  modport master (
    output signal, can_receive_next_word,
    input  data, ready, parity_error, frame_error, busy
  );

  modport slave (
    input  signal, can_receive_next_word,
    output data, ready, parity_error, frame_error, busy
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: WIDTH data bits, optional even/odd parity, 1 or 2 stop bits.
// A frame whose stop bit samples low parks in a break state until the line returns high.
// Define UART_RX_MAJORITY_EN to decide every bit by 2-of-3 vote over three adjacent
// cycles; the decision then lands one cycle after the nominal sample point.
module uart_rx_cfg #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int WIDTH      = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input logic          clock,
  input logic          resetn,
  uart_rx_cfg_if.slave bus
);

  localparam int TPB = CLOCK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(TPB) + 1;
  localparam int IW  = $clog2(WIDTH) + 1;

  localparam logic [CW-1:0] HALF = CW'(TPB / 2);
  // Reload so that consecutive decisions are exactly TPB cycles apart.
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] RELOAD = CW'(TPB - 2);
`else
  localparam logic [CW-1:0] RELOAD = CW'(TPB - 1);
`endif
  localparam logic [IW-1:0] LAST_DATA = IW'(WIDTH - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop, StBreak
  } state_e;

  state_e           state;
  logic             sync_a, line;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] shreg;
  logic             perr_acc, ferr_acc;
  logic [WIDTH-1:0] data_q;
  logic             ready_q, perr_q, ferr_q, busy_q;
  logic             act, smp;

  // Two-flop synchronizer; resets to the idle (high) level.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync_a <= 1'b1;
      line   <= 1'b1;
    end else begin
      sync_a <= bus.signal;
      line   <= sync_a;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic hist1, hist2, pend, counting;

  assign counting = (state == StStart) || (state == StData) ||
                    (state == StParity) || (state == StStop);
  assign act = pend;
  // hist2/hist1/line hold the samples at action-1, action, action+1.
  assign smp = (hist2 & hist1) | (hist2 & line) | (hist1 & line);

  // Sample history and the one-cycle deferral of each decision.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      hist1 <= 1'b1;
      hist2 <= 1'b1;
      pend  <= 1'b0;
    end else begin
      hist1 <= line;
      hist2 <= hist1;
      pend  <= counting && (cnt == '0) && !pend;
    end
  end
`else
  assign act = (cnt == '0);
  assign smp = line;
`endif

  // Frame FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state    <= StIdle;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      perr_acc <= 1'b0;
      ferr_acc <= 1'b0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      unique case (state)
        StIdle: begin
          if (!line && bus.can_receive_next_word) begin
            state  <= StStart;
            cnt    <= HALF;
            busy_q <= 1'b1;
          end
        end
        StStart: begin
          if (act) begin
            if (!smp) begin
              state    <= StData;
              cnt      <= RELOAD;
              idx      <= '0;
              perr_acc <= 1'b0;
              ferr_acc <= 1'b0;
            end else begin
              state  <= StIdle;
              busy_q <= 1'b0;
            end
          end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end
        end
        StData: begin
          if (act) begin
            shreg <= {smp, shreg[WIDTH-1:1]};
            cnt   <= RELOAD;
            if (idx == LAST_DATA) begin
              idx   <= '0;
              state <= (PARITY != 0) ? StParity : StStop;
            end else begin
              idx <= idx + IW'(1);
            end
          end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end
        end
        StParity: begin
          if (act) begin
            // Even: total ones must be even; odd: total ones must be odd.
            perr_acc <= (^shreg) ^ smp ^ (PARITY == 2);
            cnt      <= RELOAD;
            state    <= StStop;
          end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end
        end
        StStop: begin
          if (act) begin
            if (idx == LAST_STOP) begin
              data_q  <= shreg;
              ready_q <= 1'b1;
              perr_q  <= perr_acc;
              ferr_q  <= ferr_acc | ~smp;
              if (ferr_acc || !smp) begin
                state <= StBreak;
              end else begin
                state  <= StIdle;
                busy_q <= 1'b0;
              end
            end else begin
              idx      <= idx + IW'(1);
              cnt      <= RELOAD;
              ferr_acc <= ferr_acc | ~smp;
            end
          end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end
        end
        StBreak: begin
          if (line) begin
            state  <= StIdle;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= StIdle;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data         = data_q;
  assign bus.ready        = ready_q;
  assign bus.parity_error = perr_q;
  assign bus.frame_error  = ferr_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg at TPB=16 with three instances: plain 8N1, even parity, two stop bits.
// Expected words are queued per instance when a frame is driven and checked on each ready.
module tb_uart_rx_cfg;

  localparam int TPB = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clock;
  logic resetn;
  int   vectors;
  int   miscompares;

  exp_t exp_q[3][$];

  uart_rx_cfg_if #(.WIDTH(8)) i0 ();
  uart_rx_cfg_if #(.WIDTH(8)) i1 ();
  uart_rx_cfg_if #(.WIDTH(8)) i2 ();

  uart_rx_cfg #(.CLOCK_FREQ(16000), .BAUD_RATE(1000), .WIDTH(8), .PARITY(0), .STOP_BITS(1))
    d0 (.clock(clock), .resetn(resetn), .bus(i0.slave));
  uart_rx_cfg #(.CLOCK_FREQ(16000), .BAUD_RATE(1000), .WIDTH(8), .PARITY(1), .STOP_BITS(1))
    d1 (.clock(clock), .resetn(resetn), .bus(i1.slave));
  uart_rx_cfg #(.CLOCK_FREQ(16000), .BAUD_RATE(1000), .WIDTH(8), .PARITY(0), .STOP_BITS(2))
    d2 (.clock(clock), .resetn(resetn), .bus(i2.slave));

  logic [7:0] o_data [3];
  logic [2:0] o_ready, o_pe, o_fe, o_busy;

  assign o_data[0] = i0.data;
  assign o_data[1] = i1.data;
  assign o_data[2] = i2.data;
  assign o_ready   = {i2.ready, i1.ready, i0.ready};
  assign o_pe      = {i2.parity_error, i1.parity_error, i0.parity_error};
  assign o_fe      = {i2.frame_error, i1.frame_error, i0.frame_error};
  assign o_busy    = {i2.busy, i1.busy, i0.busy};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard: every ready pops one expectation; status flags must be low without ready.
  always @(negedge clock) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (o_ready[d] === 1'b1) begin
        vectors++;
        if (exp_q[d].size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_ready dev%0d: got data=%h pe=%b fe=%b, required no ready",
                   d, o_data[d], o_pe[d], o_fe[d]);
        end else begin
          e = exp_q[d].pop_front();
          if ({o_data[d], o_pe[d], o_fe[d]} !== e) begin
            miscompares++;
            $display("FAIL frame dev%0d: got data=%h pe=%b fe=%b, required data=%h pe=%b fe=%b",
                     d, o_data[d], o_pe[d], o_fe[d], e.data, e.pe, e.fe);
          end
        end
      end else if (o_pe[d] === 1'b1 || o_fe[d] === 1'b1) begin
        miscompares++;
        $display("FAIL flags_without_ready dev%0d: got pe=%b fe=%b, required 0 0",
                 d, o_pe[d], o_fe[d]);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_line(input int dev, input logic v);
    case (dev)
      0:       i0.signal = v;
      1:       i1.signal = v;
      default: i2.signal = v;
    endcase
  endtask

  task automatic set_can(input int dev, input logic v);
    case (dev)
      0:       i0.can_receive_next_word = v;
      1:       i1.can_receive_next_word = v;
      default: i2.can_receive_next_word = v;
    endcase
  endtask

  task automatic push_exp(input int dev, input logic [7:0] w, input logic pe, input logic fe);
    exp_t e;
    e.data = w;
    e.pe   = pe;
    e.fe   = fe;
    exp_q[dev].push_back(e);
  endtask

  // Drives one frame; all stop bits high except the last, which takes stop_last.
  task automatic send_frame(input int dev, input logic [7:0] w, input bit has_par,
                            input logic pbit, input int nstop, input logic stop_last,
                            input bit glitch, input bit drop_can);
    set_line(dev, 1'b0);
    repeat (TPB) tick();
    if (drop_can) set_can(dev, 1'b0);
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < TPB; c++) begin
        if (glitch && c == TPB / 2) set_line(dev, ~w[i]);
        else set_line(dev, w[i]);
        tick();
      end
    end
    if (has_par) begin
      set_line(dev, pbit);
      repeat (TPB) tick();
    end
    for (int s = 0; s < nstop; s++) begin
      set_line(dev, (s == nstop - 1) ? stop_last : 1'b1);
      repeat (TPB) tick();
    end
  endtask

  task automatic wait_drain(input int dev);
    for (int k = 0; k < 4 * TPB && exp_q[dev].size() != 0; k++) tick();
    vectors++;
    if (exp_q[dev].size() != 0) begin
      miscompares++;
      $display("FAIL drain dev%0d: got %0d pending frames, required 0", dev, exp_q[dev].size());
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    for (int d = 0; d < 3; d++) begin
      set_line(d, 1'b1);
      set_can(d, 1'b1);
    end
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      vectors += 5;
      if (o_ready[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_ready dev%0d: got %b, required 0", d, o_ready[d]);
      end
      if (o_pe[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_pe dev%0d: got %b, required 0", d, o_pe[d]);
      end
      if (o_fe[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_fe dev%0d: got %b, required 0", d, o_fe[d]);
      end
      if (o_busy[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_busy dev%0d: got %b, required 0", d, o_busy[d]);
      end
      if (o_data[d] !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_data dev%0d: got %h, required 00", d, o_data[d]);
      end
    end
    resetn = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    push_exp(0, 8'hA5, 1'b0, 1'b0);
    push_exp(0, 8'h3C, 1'b0, 1'b0);
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    set_line(0, 1'b1);
    repeat (2 * TPB) tick();
    wait_drain(0);
    vectors++;
    if (o_data[0] !== 8'h3C || o_busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_hold: got data=%h busy=%b, required data=3c busy=0",
               o_data[0], o_busy[0]);
    end
  endtask

  task automatic test_parity();
    push_exp(1, 8'h07, 1'b1, 1'b0);
    send_frame(1, 8'h07, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    push_exp(1, 8'h07, 1'b0, 1'b0);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0);
    push_exp(1, 8'h00, 1'b1, 1'b0);
    send_frame(1, 8'h00, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0);
    push_exp(1, 8'h96, 1'b0, 1'b0);
    send_frame(1, 8'h96, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    set_line(1, 1'b1);
    repeat (2 * TPB) tick();
    wait_drain(1);
  endtask

  task automatic test_stop_break();
    push_exp(2, 8'h5A, 1'b0, 1'b1);
    send_frame(2, 8'h5A, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      repeat (TPB) tick();
      vectors++;
      if (o_busy[2] !== 1'b1) begin
        miscompares++;
        $display("FAIL break_busy bit%0d: got %b, required 1", k, o_busy[2]);
      end
    end
    set_line(2, 1'b1);
    repeat (4) tick();
    vectors++;
    if (o_busy[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL break_release_busy: got %b, required 0", o_busy[2]);
    end
    wait_drain(2);
    push_exp(2, 8'hC3, 1'b0, 1'b0);
    send_frame(2, 8'hC3, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0);
    repeat (2 * TPB) tick();
    wait_drain(2);
  endtask

  task automatic test_glitch();
    set_line(0, 1'b0);
    repeat (4) tick();
    vectors++;
    if (o_busy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_busy_start: got %b, required 1", o_busy[0]);
    end
    set_line(0, 1'b1);
    repeat (TPB / 2 + 3) tick();
    vectors++;
    if (o_busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_busy_end: got %b, required 0", o_busy[0]);
    end
    repeat (2 * TPB) tick();
    vectors++;
    if (o_data[0] !== 8'h3C) begin
      miscompares++;
      $display("FAIL glitch_data_hold: got %h, required 3c", o_data[0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] w;
    w = 8'h55;
    set_line(0, 1'b0);
    repeat (TPB) tick();
    for (int i = 0; i < 3; i++) begin
      set_line(0, w[i]);
      repeat (TPB) tick();
    end
    set_line(0, w[3]);
    repeat (TPB / 2) tick();
    resetn = 1'b0;
    set_line(0, 1'b1);
    repeat (3) tick();
    vectors++;
    if (o_busy[0] !== 1'b0 || o_data[0] !== 8'h00) begin
      miscompares++;
      $display("FAIL midreset_state: got busy=%b data=%h, required busy=0 data=00",
               o_busy[0], o_data[0]);
    end
    resetn = 1'b1;
    repeat (5) tick();
    push_exp(0, 8'h81, 1'b0, 1'b0);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    set_line(0, 1'b1);
    repeat (2 * TPB) tick();
    wait_drain(0);
  endtask

  task automatic test_can_receive();
    set_can(0, 1'b0);
    send_frame(0, 8'h11, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    set_line(0, 1'b1);
    repeat (2 * TPB) tick();
    vectors++;
    if (o_busy[0] !== 1'b0 || o_data[0] !== 8'h81) begin
      miscompares++;
      $display("FAIL can_low_ignored: got busy=%b data=%h, required busy=0 data=81",
               o_busy[0], o_data[0]);
    end
    set_can(0, 1'b1);
    push_exp(0, 8'h22, 1'b0, 1'b0);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1);
    set_line(0, 1'b1);
    repeat (2 * TPB) tick();
    wait_drain(0);
    set_can(0, 1'b1);
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic test_majority();
    push_exp(0, 8'hF0, 1'b0, 1'b0);
    send_frame(0, 8'hF0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0);
    set_line(0, 1'b1);
    repeat (2 * TPB) tick();
    wait_drain(0);
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    resetn      = 1'b0;
    i0.signal = 1'b1; i1.signal = 1'b1; i2.signal = 1'b1;
    i0.can_receive_next_word = 1'b1;
    i1.can_receive_next_word = 1'b1;
    i2.can_receive_next_word = 1'b1;
    test_reset();
    test_back_to_back();
    test_parity();
    test_stop_break();
    test_glitch();
    test_reset_mid_frame();
    test_can_receive();
`ifdef UART_RX_MAJORITY_EN
    test_majority();
`endif
    for (int d = 0; d < 3; d++) wait_drain(d);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
